padctl_gen2: RTL and testbench

Parametrised second-generation pad controller between the chip pad ring and the peripheral `cio_*` ports. It generalises the GPIO pad count and adds several features:
- per-pad input synchronisation and optional glitch filtering;
- a reset-time strap sampling state machine, so JTAG/SPI mode and boot strap are latched once rather than followed live;
- explicit out/oe pad drive, so tri-state resolution happens in the pad cells.

---
 rtl/padctl_gen2_pkg.sv | 33 +++
 rtl/padctl_in_filter.sv | 45 ++++
 rtl/padctl_gen2.sv | 169 ++++++++++++++++
 tb/tb_padctl_gen2.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/padctl_gen2_pkg.sv
// Shared types and constants for the second-generation pad controller.
package padctl_gen2_pkg;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_WAIT,
    ST_SAMPLE,
    ST_LOCKED
  } strap_state_e;

  // Dual-purpose pad indices
  localparam int unsigned DpsTck  = 0;
  localparam int unsigned DpsTdi  = 1;
  localparam int unsigned DpsTdo  = 2;
  localparam int unsigned DpsTms  = 3;
  localparam int unsigned DpsTrst = 4;
  localparam int unsigned DpsSrst = 5;
  localparam int unsigned DpsMode = 6;
  localparam int unsigned DpsBoot = 7;

  // Values seen by an interface that is not routed to the DPS pads
  localparam logic IdleSck   = 1'b0;
  localparam logic IdleMosi  = 1'b0;
  localparam logic IdleCsb   = 1'b1;
  localparam logic IdleTck   = 1'b0;
  localparam logic IdleTdi   = 1'b0;
  localparam logic IdleTms   = 1'b0;
  localparam logic IdleTrstN = 1'b1;
  localparam logic IdleSrstN = 1'b1;
  // TAP held in reset until the straps are locked
  localparam logic HoldTrstN = 1'b0;

endpackage

// File: rtl/padctl_in_filter.sv
// One-bit pad input: synchroniser chain followed by a glitch filter.
module padctl_in_filter
  import padctl_gen2_pkg::*;
#(
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned FilterCycles = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  output logic sync_o,
  output logic filt_o
);

  logic [SyncStages-1:0] r_sync;
  logic [3:0]            r_cnt;
  logic                  r_filt;
  logic                  w_sync;

  assign w_sync = r_sync[SyncStages-1];
  assign sync_o = w_sync;
  assign filt_o = r_filt;

  // Shift the pad value through the synchroniser chain
  always_ff @(posedge clk_i) begin
    if (rst_i) r_sync <= '0;
    else       r_sync <= {r_sync[SyncStages-2:0], pad_i};
  end

  // Accept a new level only after FilterCycles consecutive differing samples
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (w_sync == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == 4'(FilterCycles - 1)) begin
      r_filt <= w_sync;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/padctl_gen2.sv
// Pad controller: GPIO/UART/DPS input conditioning, strap latching, JTAG/SPI mux.
module padctl_gen2
  import padctl_gen2_pkg::*;
#(
  parameter int unsigned NumGpio      = 16,
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned FilterCycles = 4,
  parameter int unsigned StrapDelay   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumGpio-1:0] gpio_pad_i,
  output logic [NumGpio-1:0] gpio_pad_o,
  output logic [NumGpio-1:0] gpio_pad_oe_o,
  input  logic [NumGpio-1:0] gpio_filter_en_i,
  input  logic [31:0]        cio_gpio_d2p,
  input  logic [31:0]        cio_gpio_en_d2p,
  output logic [31:0]        cio_gpio_p2d,
  input  logic               uart_rx_pad_i,
  output logic               uart_tx_pad_o,
  output logic               uart_tx_pad_oe_o,
  input  logic               cio_uart_tx_d2p,
  input  logic               cio_uart_tx_en_d2p,
  output logic               cio_uart_rx_p2d,
  input  logic [7:0]         dps_pad_i,
  output logic [7:0]         dps_pad_o,
  output logic [7:0]         dps_pad_oe_o,
  output logic               cio_spi_device_sck_p2d,
  output logic               cio_spi_device_csb_p2d,
  output logic               cio_spi_device_mosi_p2d,
  input  logic               cio_spi_device_miso_d2p,
  input  logic               cio_spi_device_miso_en_d2p,
  output logic               cio_jtag_tck_p2d,
  output logic               cio_jtag_tms_p2d,
  output logic               cio_jtag_trst_n_p2d,
  output logic               cio_jtag_srst_n_p2d,
  output logic               cio_jtag_tdi_p2d,
  input  logic               cio_jtag_tdo_d2p,
  output logic               jtag_spi_n_o,
  output logic               boot_strap_o,
  output logic               strap_valid_o
);

  logic [NumGpio-1:0] w_gpio_sync;
  logic [NumGpio-1:0] w_gpio_filt;
  logic [NumGpio-1:0] w_gpio_in;
  logic [7:0]         w_dps_sync;
  logic [7:0]         w_dps_filt_unused;
  logic               w_uart_filt_unused;
  logic               w_unused;

  strap_state_e r_state, w_state_nxt;
  logic [7:0]   r_cnt;
  logic         r_jtag_spi_n;
  logic         r_boot_strap;

  for (genvar g = 0; g < NumGpio; g++) begin : g_gpio
    padctl_in_filter #(.SyncStages(SyncStages), .FilterCycles(FilterCycles)) u_in (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .pad_i (gpio_pad_i[g]),
      .sync_o(w_gpio_sync[g]),
      .filt_o(w_gpio_filt[g])
    );
  end

  padctl_in_filter #(.SyncStages(SyncStages), .FilterCycles(FilterCycles)) u_uart_rx (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .pad_i (uart_rx_pad_i),
    .sync_o(cio_uart_rx_p2d),
    .filt_o(w_uart_filt_unused)
  );

  for (genvar d = 0; d < 8; d++) begin : g_dps
    padctl_in_filter #(.SyncStages(SyncStages), .FilterCycles(FilterCycles)) u_in (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .pad_i (dps_pad_i[d]),
      .sync_o(w_dps_sync[d]),
      .filt_o(w_dps_filt_unused[d])
    );
  end

  assign w_unused = ^{cio_gpio_d2p[31:NumGpio], cio_gpio_en_d2p[31:NumGpio],
                      w_dps_sync[DpsTdo], w_dps_filt_unused, w_uart_filt_unused};

  assign w_gpio_in        = (w_gpio_filt & gpio_filter_en_i) | (w_gpio_sync & ~gpio_filter_en_i);
  assign gpio_pad_o       = cio_gpio_d2p[NumGpio-1:0];
  assign gpio_pad_oe_o    = cio_gpio_en_d2p[NumGpio-1:0];
  assign uart_tx_pad_o    = cio_uart_tx_d2p;
  assign uart_tx_pad_oe_o = cio_uart_tx_en_d2p;
  assign jtag_spi_n_o     = r_jtag_spi_n;
  assign boot_strap_o     = r_boot_strap;
  assign strap_valid_o    = (r_state == ST_LOCKED);

  // Core-side GPIO input word with the latched straps appended
  always_comb begin
    cio_gpio_p2d              = '0;
    cio_gpio_p2d[NumGpio-1:0] = w_gpio_in;
    cio_gpio_p2d[NumGpio]     = r_jtag_spi_n;
    cio_gpio_p2d[NumGpio+1]   = r_boot_strap;
  end

  // Strap state register, wait counter and latched strap values
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_RESET;
      r_cnt        <= '0;
      r_jtag_spi_n <= 1'b0;
      r_boot_strap <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_WAIT:   r_cnt <= r_cnt + 8'd1;
        ST_SAMPLE: begin
          r_jtag_spi_n <= w_dps_sync[DpsMode];
          r_boot_strap <= w_dps_sync[DpsBoot];
        end
        ST_LOCKED: ;
        default:   r_cnt <= '0;
      endcase
    end
  end

  // Strap sequencing: wait StrapDelay cycles, sample once, then lock
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RESET:  w_state_nxt = ST_WAIT;
      ST_WAIT:   if (r_cnt == 8'(StrapDelay - 1)) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = ST_LOCKED;
      default:   w_state_nxt = ST_LOCKED;
    endcase
  end

  // DPS routing to JTAG or SPI once locked; idle/held values before that
  always_comb begin
    dps_pad_o               = '0;
    dps_pad_oe_o            = '0;
    cio_spi_device_sck_p2d  = IdleSck;
    cio_spi_device_mosi_p2d = IdleMosi;
    cio_spi_device_csb_p2d  = IdleCsb;
    cio_jtag_tck_p2d        = IdleTck;
    cio_jtag_tdi_p2d        = IdleTdi;
    cio_jtag_tms_p2d        = IdleTms;
    cio_jtag_trst_n_p2d     = HoldTrstN;
    cio_jtag_srst_n_p2d     = IdleSrstN;
    if (r_state == ST_LOCKED) begin
      if (r_jtag_spi_n) begin
        cio_jtag_tck_p2d     = w_dps_sync[DpsTck];
        cio_jtag_tdi_p2d     = w_dps_sync[DpsTdi];
        cio_jtag_tms_p2d     = w_dps_sync[DpsTms];
        cio_jtag_trst_n_p2d  = w_dps_sync[DpsTrst];
        cio_jtag_srst_n_p2d  = w_dps_sync[DpsSrst];
        dps_pad_o[DpsTdo]    = cio_jtag_tdo_d2p;
        dps_pad_oe_o[DpsTdo] = 1'b1;
      end else begin
        cio_jtag_trst_n_p2d     = IdleTrstN;
        cio_spi_device_sck_p2d  = w_dps_sync[DpsTck];
        cio_spi_device_mosi_p2d = w_dps_sync[DpsTdi];
        cio_spi_device_csb_p2d  = w_dps_sync[DpsTms];
        dps_pad_o[DpsTdo]       = cio_spi_device_miso_d2p;
        dps_pad_oe_o[DpsTdo]    = cio_spi_device_miso_en_d2p;
      end
    end
  end

endmodule

// File: tb/tb_padctl_gen2.sv
// Directed bench for padctl_gen2 with hand-computed expectations.
module tb_padctl_gen2;

  localparam int unsigned NG = 16;
  localparam int unsigned SS = 2;
  localparam int unsigned FC = 4;
  localparam int unsigned SD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NG-1:0] gpio_pad_i, gpio_pad_o, gpio_pad_oe_o, gpio_filter_en_i;
  logic [31:0]   cio_gpio_d2p, cio_gpio_en_d2p, cio_gpio_p2d;
  logic          uart_rx_pad_i, uart_tx_pad_o, uart_tx_pad_oe_o;
  logic          cio_uart_tx_d2p, cio_uart_tx_en_d2p, cio_uart_rx_p2d;
  logic [7:0]    dps_pad_i, dps_pad_o, dps_pad_oe_o;
  logic          sck, csb, mosi, miso, miso_en;
  logic          tck, tms, trst_n, srst_n, tdi, tdo;
  logic          jtag_spi_n, boot_strap, strap_valid;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic        seen;

  always #5 clk = ~clk;

  padctl_gen2 #(.NumGpio(NG), .SyncStages(SS), .FilterCycles(FC), .StrapDelay(SD)) dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .gpio_pad_i                (gpio_pad_i),
    .gpio_pad_o                (gpio_pad_o),
    .gpio_pad_oe_o             (gpio_pad_oe_o),
    .gpio_filter_en_i          (gpio_filter_en_i),
    .cio_gpio_d2p              (cio_gpio_d2p),
    .cio_gpio_en_d2p           (cio_gpio_en_d2p),
    .cio_gpio_p2d              (cio_gpio_p2d),
    .uart_rx_pad_i             (uart_rx_pad_i),
    .uart_tx_pad_o             (uart_tx_pad_o),
    .uart_tx_pad_oe_o          (uart_tx_pad_oe_o),
    .cio_uart_tx_d2p           (cio_uart_tx_d2p),
    .cio_uart_tx_en_d2p        (cio_uart_tx_en_d2p),
    .cio_uart_rx_p2d           (cio_uart_rx_p2d),
    .dps_pad_i                 (dps_pad_i),
    .dps_pad_o                 (dps_pad_o),
    .dps_pad_oe_o              (dps_pad_oe_o),
    .cio_spi_device_sck_p2d    (sck),
    .cio_spi_device_csb_p2d    (csb),
    .cio_spi_device_mosi_p2d   (mosi),
    .cio_spi_device_miso_d2p   (miso),
    .cio_spi_device_miso_en_d2p(miso_en),
    .cio_jtag_tck_p2d          (tck),
    .cio_jtag_tms_p2d          (tms),
    .cio_jtag_trst_n_p2d       (trst_n),
    .cio_jtag_srst_n_p2d       (srst_n),
    .cio_jtag_tdi_p2d          (tdi),
    .cio_jtag_tdo_d2p          (tdo),
    .jtag_spi_n_o              (jtag_spi_n),
    .boot_strap_o              (boot_strap),
    .strap_valid_o             (strap_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance n rising edges, landing on the following falling edge
  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; gpio_pad_i = '0; gpio_filter_en_i = '0;
    cio_gpio_d2p = '0; cio_gpio_en_d2p = '0;
    uart_rx_pad_i = 1'b0; cio_uart_tx_d2p = 1'b0; cio_uart_tx_en_d2p = 1'b0;
    dps_pad_i = 8'h40; miso = 1'b0; miso_en = 1'b0; tdo = 1'b0;
    tick(3);
    gpio_pad_i = 16'hFFFF;
    tick(2);
    check_eq("rst_p2d", cio_gpio_p2d, 32'h0);
    check_eq("rst_uart_rx", 32'(cio_uart_rx_p2d), 32'h0);
    check_eq("rst_valid", 32'(strap_valid), 32'h0);
    check_eq("rst_trst_n", 32'(trst_n), 32'h0);
    check_eq("rst_csb", 32'(csb), 32'h1);
    check_eq("rst_dps_oe", 32'(dps_pad_oe_o), 32'h0);

    // JTAG strap: DPS6=1, DPS7=0
    gpio_pad_i = '0;
    rst = 1'b0;
    for (int k = 1; k <= int'(SD) + 2; k++) begin
      tick(1);
      if (k == int'(SD) + 1) begin
        check_eq("pre_valid", 32'(strap_valid), 32'h0);
        check_eq("pre_dps_oe", 32'(dps_pad_oe_o), 32'h0);
        check_eq("pre_trst_n", 32'(trst_n), 32'h0);
        check_eq("pre_csb", 32'(csb), 32'h1);
        check_eq("pre_mode", 32'(jtag_spi_n), 32'h0);
      end
    end
    check_eq("j_valid", 32'(strap_valid), 32'h1);
    check_eq("j_mode", 32'(jtag_spi_n), 32'h1);
    check_eq("j_boot", 32'(boot_strap), 32'h0);
    check_eq("j_p2d", cio_gpio_p2d, 32'h0001_0000);
    tdo = 1'b1;
    #1;
    check_eq("j_dps_o", 32'(dps_pad_o), 32'h04);
    check_eq("j_dps_oe", 32'(dps_pad_oe_o), 32'h04);

    dps_pad_i = 8'h41;
    tick(1);
    check_eq("j_tck_lat1", 32'(tck), 32'h0);
    tick(1);
    check_eq("j_tck_lat2", 32'(tck), 32'h1);
    check_eq("j_sck_idle", 32'(sck), 32'h0);
    check_eq("j_csb_idle", 32'(csb), 32'h1);
    check_eq("j_trst_n", 32'(trst_n), 32'h0);

    // Combinational output path
    cio_gpio_en_d2p = 32'h0000_8001; cio_gpio_d2p = 32'hFFFF_FFFF;
    cio_uart_tx_d2p = 1'b1; cio_uart_tx_en_d2p = 1'b1;
    #1;
    check_eq("gpio_oe", 32'(gpio_pad_oe_o), 32'h8001);
    check_eq("gpio_o", 32'(gpio_pad_o), 32'hFFFF);
    check_eq("uart_tx", 32'({uart_tx_pad_oe_o, uart_tx_pad_o}), 32'h3);

    // UART RX latency, never filtered
    uart_rx_pad_i = 1'b1;
    tick(1);
    check_eq("uart_rx_lat1", 32'(cio_uart_rx_p2d), 32'h0);
    tick(1);
    check_eq("uart_rx_lat2", 32'(cio_uart_rx_p2d), 32'h1);

    // Unfiltered GPIO latency
    gpio_pad_i = 16'h0008;
    tick(1);
    check_eq("gp3_lat1", cio_gpio_p2d, 32'h0001_0000);
    tick(1);
    check_eq("gp3_lat2", cio_gpio_p2d, 32'h0001_0008);

    // Filter on GP5: 3-cycle pulse suppressed
    gpio_filter_en_i = 16'h0020;
    gpio_pad_i = 16'h0028;
    tick(3);
    gpio_pad_i = 16'h0008;
    seen = 1'b0;
    repeat (10) begin
      tick(1);
      seen = seen | cio_gpio_p2d[5];
    end
    check_eq("flt_short", 32'(seen), 32'h0);

    // 4-cycle pulse passes after SyncStages+FilterCycles edges
    gpio_pad_i = 16'h0028;
    tick(4);
    gpio_pad_i = 16'h0008;
    tick(1);
    check_eq("flt_long_e5", 32'(cio_gpio_p2d[5]), 32'h0);
    tick(1);
    check_eq("flt_long_e6", 32'(cio_gpio_p2d[5]), 32'h1);
    gpio_filter_en_i = 16'h0000;
    #1;
    check_eq("flt_bypass", 32'(cio_gpio_p2d[5]), 32'h0);
    gpio_filter_en_i = 16'h0020;
    #1;
    check_eq("flt_restore", 32'(cio_gpio_p2d[5]), 32'h1);

    // Reset while locked
    rst = 1'b1;
    tick(1);
    check_eq("r2_valid", 32'(strap_valid), 32'h0);
    check_eq("r2_mode", 32'(jtag_spi_n), 32'h0);
    check_eq("r2_p2d", cio_gpio_p2d, 32'h0);
    check_eq("r2_uart_rx", 32'(cio_uart_rx_p2d), 32'h0);

    // SPI strap: DPS6=0, DPS7=1, CSB idle high
    dps_pad_i = 8'h88;
    tick(1);
    rst = 1'b0; miso = 1'b1; miso_en = 1'b1;
    for (int k = 1; k <= int'(SD) + 2; k++) begin
      tick(1);
      if (k == int'(SD) + 1) check_eq("s_pre_valid", 32'(strap_valid), 32'h0);
    end
    check_eq("s_valid", 32'(strap_valid), 32'h1);
    check_eq("s_boot", 32'(boot_strap), 32'h1);
    check_eq("s_mode", 32'(jtag_spi_n), 32'h0);
    check_eq("s_p2d_straps", 32'(cio_gpio_p2d[17:16]), 32'h2);
    check_eq("s_jtag_idle", 32'({tck, tdi, tms, trst_n, srst_n}), 32'h03);
    check_eq("s_csb_high", 32'(csb), 32'h1);
    check_eq("s_dps_o", 32'(dps_pad_o), 32'h04);
    check_eq("s_dps_oe", 32'(dps_pad_oe_o), 32'h04);
    miso_en = 1'b0;
    #1;
    check_eq("s_miso_oe_off", 32'(dps_pad_oe_o), 32'h00);

    dps_pad_i = 8'h01;
    tick(2);
    check_eq("s_csb_low", 32'(csb), 32'h0);
    check_eq("s_sck", 32'(sck), 32'h1);
    dps_pad_i = 8'h41;
    tick(4);
    check_eq("s_mode_held", 32'(jtag_spi_n), 32'h0);
    check_eq("s_boot_held", 32'(boot_strap), 32'h1);
    check_eq("s_valid_held", 32'(strap_valid), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
